// File: rtl/write_state_machine_pkg.sv
// Shared instruction-bus definitions for the four-beat RAM sequencers.
package write_state_machine_pkg;

    localparam int unsigned INSTR_W      = 21;
    localparam int unsigned RAM_ADDR_W   = 8;
    localparam int unsigned WORD_GROUP_W = 6;
    localparam int unsigned BEAT_W       = 2;
    localparam int unsigned INSEL_W      = 2;
    localparam int unsigned ALU_OP_W     = 4;
    localparam int unsigned GCMD_W       = 3;

    // Field bit positions, MSB first
    localparam int unsigned SAVE_CORE_BIT = 20;
    localparam int unsigned RAM_WRITE_BIT = 19;
    localparam int unsigned ADDR_MSB      = 18;
    localparam int unsigned ADDR_LSB      = 11;
    localparam int unsigned INSEL_MSB     = 10;
    localparam int unsigned INSEL_LSB     = 9;
    localparam int unsigned OUT_SEL_BIT   = 8;
    localparam int unsigned OUT_EN_BIT    = 7;
    localparam int unsigned ALU_OP_MSB    = 6;
    localparam int unsigned ALU_OP_LSB    = 3;
    localparam int unsigned GCMD_MSB      = 2;
    localparam int unsigned GCMD_LSB      = 0;

    localparam logic [ALU_OP_W-1:0] ALU_OP_PASS = 4'hC;
    localparam logic [GCMD_W-1:0]   GCMD_NONE   = 3'd0;

    typedef struct packed {
        logic                  save_core_selection;
        logic                  ram_write_bit;
        logic [RAM_ADDR_W-1:0] address;
        logic [INSEL_W-1:0]    input_select;
        logic                  output_select;
        logic                  output_enable;
        logic [ALU_OP_W-1:0]   alu_opcode;
        logic [GCMD_W-1:0]     global_command;
    } instr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_BEAT3 = 2'd3
    } wsm_state_t;

    // Place each field at its bit position in the instruction word
    function automatic logic [INSTR_W-1:0] pack_instruction(input instr_fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[SAVE_CORE_BIT]            = f.save_core_selection;
        w[RAM_WRITE_BIT]            = f.ram_write_bit;
        w[ADDR_MSB:ADDR_LSB]        = f.address;
        w[INSEL_MSB:INSEL_LSB]      = f.input_select;
        w[OUT_SEL_BIT]              = f.output_select;
        w[OUT_EN_BIT]               = f.output_enable;
        w[ALU_OP_MSB:ALU_OP_LSB]    = f.alu_opcode;
        w[GCMD_MSB:GCMD_LSB]        = f.global_command;
        return w;
    endfunction

endpackage

// File: rtl/write_state_machine_instruction_encoder.sv
// Combinational packer of instruction fields into the 21-bit bus word.
module instruction_encoder
    import write_state_machine_pkg::*;
(
    input  logic                save_core_selection,
    input  logic                ram_write_bit,
    input  logic [7:0]          address,
    input  logic [1:0]          input_select,
    input  logic                output_select,
    input  logic                output_enable,
    input  logic [3:0]          alu_opcode,
    input  logic [2:0]          global_command,
    output logic [20:0]         instruction
);

    instr_fields_t fields;

    // Gather the individual fields and pack them into the bus word
    always_comb begin
        fields                     = '0;
        fields.save_core_selection = save_core_selection;
        fields.ram_write_bit       = ram_write_bit;
        fields.address             = address;
        fields.input_select        = input_select;
        fields.output_select       = output_select;
        fields.output_enable       = output_enable;
        fields.alu_opcode          = alu_opcode;
        fields.global_command      = global_command;
        instruction                = pack_instruction(fields);
    end

endmodule

// File: rtl/write_state_machine.sv
// Four-beat RAM write burst sequencer on the shared, tri-stated instruction bus.
module write_state_machine
    import write_state_machine_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  address_i,
    input  logic [1:0]  source_i,
    input  logic        start_i,
    output logic [20:0] instruction_o,
    output logic        done_o,
    output logic        busy_o
);

    wsm_state_t                state;
    wsm_state_t                state_next;
    logic [WORD_GROUP_W-1:0]   addr;
    logic [INSEL_W-1:0]        src;

    logic [WORD_GROUP_W-1:0]   beat_group;
    logic [INSEL_W-1:0]        beat_src;
    logic [BEAT_W-1:0]         beat;
    logic                      drive_en;
    logic [INSTR_W-1:0]        instr_word;

    // State register and burst-parameter latch; reset overrides any start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            addr  <= '0;
            src   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start_i) begin
                addr <= address_i;
                src  <= source_i;
            end
        end
    end

    // Next-state: start only from IDLE, beats advance unconditionally
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  state_next = start_i ? ST_BEAT1 : ST_IDLE;
            ST_BEAT1: state_next = ST_BEAT2;
            ST_BEAT2: state_next = ST_BEAT3;
            ST_BEAT3: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs: beat 0 comes straight from the live inputs, later beats from the latch
    always_comb begin
        beat_group = addr;
        beat_src   = src;
        beat       = '0;
        drive_en   = 1'b1;
        done_o     = 1'b0;
        busy_o     = 1'b1;
        unique case (state)
            ST_IDLE: begin
                beat_group = address_i;
                beat_src   = source_i;
                beat       = 2'd0;
                drive_en   = start_i;
                busy_o     = 1'b0;
            end
            ST_BEAT1: beat = 2'd1;
            ST_BEAT2: beat = 2'd2;
            ST_BEAT3: begin
                beat   = 2'd3;
                done_o = 1'b1;
            end
            default: begin
                drive_en = 1'b0;
                busy_o   = 1'b0;
            end
        endcase
    end

    instruction_encoder u_encoder (
        .save_core_selection (1'b0),
        .ram_write_bit       (1'b1),
        .address             ({beat_group, beat}),
        .input_select        (beat_src),
        .output_select       (1'b0),
        .output_enable       (1'b0),
        .alu_opcode          (ALU_OP_PASS),
        .global_command      (GCMD_NONE),
        .instruction         (instr_word)
    );

    // Bus is released whenever the sequencer is idle and not starting
    assign instruction_o = drive_en ? instr_word : {INSTR_W{1'bz}};

endmodule

// File: tb/tb_write_state_machine.sv
// Scoreboard bench for write_state_machine with a queue-based burst model.
module tb_write_state_machine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  address_i;
    logic [1:0]  source_i;
    logic        start_i;
    wire  [20:0] instruction_o;
    logic        done_o;
    logic        busy_o;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          stim_done   = 1'b0;

    typedef struct {
        bit          drive;
        logic [20:0] word;
        bit          done;
        bit          busy;
    } exp_t;

    typedef struct {
        logic [20:0] word;
        bit          done;
    } beat_t;

    exp_t  sb_q[$];
    beat_t pend[$];

    write_state_machine dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .address_i     (address_i),
        .source_i      (source_i),
        .start_i       (start_i),
        .instruction_o (instruction_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected write instruction built from the field values with arithmetic
    function automatic logic [20:0] write_word(input int unsigned grp, input int unsigned beat,
                                               input int unsigned src);
        int unsigned v;
        v = (1 << 19) + ((grp * 4 + beat) << 11) + (src << 9) + (12 << 3);
        return v[20:0];
    endfunction

    // Apply one cycle of stimulus and record what the bus must show in that cycle
    task automatic cycle(input bit rst, input bit start, input logic [5:0] a, input logic [1:0] s);
        exp_t e;
        rst_i     = rst;
        start_i   = start;
        address_i = a;
        source_i  = s;
        if (pend.size() > 0) begin
            beat_t b;
            b      = pend.pop_front();
            e.drive = 1'b1;
            e.word  = b.word;
            e.done  = b.done;
            e.busy  = 1'b1;
        end else if (start) begin
            e.drive = 1'b1;
            e.word  = write_word(a, 0, s);
            e.done  = 1'b0;
            e.busy  = 1'b0;
            if (!rst) begin
                for (int unsigned k = 1; k < 4; k++) begin
                    beat_t nb;
                    nb.word = write_word(a, k, s);
                    nb.done = (k == 3);
                    pend.push_back(nb);
                end
            end
        end else begin
            e.drive = 1'b0;
            e.word  = '0;
            e.done  = 1'b0;
            e.busy  = 1'b0;
        end
        if (rst) pend.delete();
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expected entry each cycle
    initial begin
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                exp_t e;
                bit   bad;
                bit   released;
                e        = sb_q.pop_front();
                bad      = 1'b0;
                released = (instruction_o === {21{1'bz}}) || (instruction_o === 21'h0);
                if (e.drive && instruction_o !== e.word) begin
                    $display("FAIL instr @%0t: got %h want %h", $time, instruction_o, e.word);
                    bad = 1'b1;
                end
                if (!e.drive && !released) begin
                    $display("FAIL release @%0t: got %h want z", $time, instruction_o);
                    bad = 1'b1;
                end
                if (done_o !== e.done) begin
                    $display("FAIL done @%0t: got %b want %b", $time, done_o, e.done);
                    bad = 1'b1;
                end
                if (busy_o !== e.busy) begin
                    $display("FAIL busy @%0t: got %b want %b", $time, busy_o, e.busy);
                    bad = 1'b1;
                end
                vectors++;
                if (bad) miscompares++;
            end
        end
    end

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        address_i = '0;
        source_i  = '0;
        @(posedge clk_i);
        #1;
        cycle(1, 0, 6'h00, 2'b00);
        repeat (10) cycle(0, 0, 6'h15, 2'b11);

        // Basic burst with input changes after the start cycle
        cycle(0, 1, 6'h2A, 2'b01);
        cycle(0, 0, 6'h00, 2'b10);
        cycle(0, 0, 6'h00, 2'b10);
        cycle(0, 0, 6'h00, 2'b10);
        repeat (2) cycle(0, 0, 6'h00, 2'b10);

        // Start held high: back-to-back bursts at the top address group
        repeat (12) cycle(0, 1, 6'h3F, 2'b11);
        repeat (2) cycle(0, 0, 6'h3F, 2'b11);

        // Reset during BEAT2, then a fresh burst
        cycle(0, 1, 6'h11, 2'b10);
        cycle(0, 0, 6'h11, 2'b10);
        cycle(1, 0, 6'h11, 2'b10);
        repeat (2) cycle(0, 0, 6'h11, 2'b10);
        cycle(0, 1, 6'h05, 2'b00);
        repeat (4) cycle(0, 0, 6'h05, 2'b00);

        // Start pulses during BEAT1/BEAT2 are ignored
        cycle(0, 1, 6'h20, 2'b01);
        cycle(0, 1, 6'h21, 2'b10);
        cycle(0, 1, 6'h22, 2'b11);
        repeat (3) cycle(0, 0, 6'h22, 2'b11);

        // Reset together with start while idle
        cycle(1, 1, 6'h33, 2'b01);
        repeat (2) cycle(0, 0, 6'h33, 2'b01);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit s;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 2) == 0);
            cycle(r, s, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
        end
        repeat (4) cycle(0, 0, 6'h00, 2'b00);
        stim_done = 1'b1;
    end

    // Termination with a bounded drain of the scoreboard
    initial begin
        int unsigned guard;
        guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk_i);
            guard++;
        end
        if (!stim_done) begin
            $display("FAIL timeout: stimulus not finished after %0d cycles", guard);
            miscompares++;
        end
        repeat (2) @(posedge clk_i);
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_state_machine.md
# write_state_machine

Issues a four-beat RAM write burst on the shared 21-bit instruction bus, the write-side counterpart of the four-beat read sequencer. It is started by the instruction-level controller with a 6-bit word-group address and a data source select. It drives one write instruction per cycle to RAM addresses {address, 2'd0} through {address, 2'd3}, then pulses done. It releases the bus (high-Z) whenever it is idle, so other sequencers can share it.

## Interface
- No parameters; widths are fixed by the instruction format in the shared package.
- clk_i  input  1  system clock, all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- address_i  input  6  word-group address; RAM address = {address_i, beat[1:0]}
- source_i  input  2  input_select value carried by every beat (data source feeding RAM)
- start_i  input  1  request a burst; sampled only in IDLE
- instruction_o  output  21  instruction bus; high-Z when not driving
- done_o  output  1  high during the final (4th) beat only
- busy_o  output  1  high while state != IDLE

## Operation
- Instruction field layout, MSB first:
  - save_core_selection[20]
  - ram_write_bit[19]
  - address[18:11]
  - input_select[10:9]
  - output_select[8]
  - output_enable[7]
  - alu_opcode[6:3]
  - global_command[2:0]
- Fixed field values in every beat: save_core_selection=0, ram_write_bit=1, output_select=0, output_enable=0, alu_opcode=4'hC, global_command=3'd0.
- Variable fields:
  - address = {addr, beat}.
  - input_select = src.
- States are IDLE, BEAT1, BEAT2, BEAT3. Beat 0 is issued combinationally from IDLE in the start cycle.
- IDLE:
  - Without start_i: instruction_o = Z, done_o=0.
  - With start_i: drive beat 0 from the live address_i/source_i, latch address_i and source_i into addr/src, and go to BEAT1.
- BEAT1, BEAT2: drive beats 1 and 2 from the latched addr/src; advance unconditionally.
- BEAT3: drive beat 3, done_o=1; go to IDLE.
- start_i in BEAT1..BEAT3 is ignored. address_i and source_i changes after the start cycle have no effect.
- No back-pressure: the burst always runs four consecutive cycles.

## Timing
- Start at cycle T:
  - beat0 at T, beat1 at T+1, beat2 at T+2, beat3 with done_o at T+3.
  - busy_o is high T+1..T+3.
- Back-to-back bursts: start_i at T+4 (the IDLE cycle after DONE) issues the new beat 0 at T+4, with zero gap cycles.
- Reset values:
  - state=IDLE, done_o=0, busy_o=0, instruction_o=Z (unless start_i is high), addr/src=0.
- Reset mid-burst takes priority over everything:
  - The next cycle is IDLE and no further beats are issued.
  - done_o is never asserted for the aborted burst.
  - If rst_i and start_i are high together while in IDLE, beat 0 is still driven combinationally in that cycle. The state remains IDLE afterwards. The controller must not start during reset.
- Address wrap: addr=6'h3F produces RAM addresses 8'hFC..8'hFF. There is no carry into other fields.

## Structure
- Shared package (common with the read sequencer):
  - field bit positions and widths
  - ALU_OP_PASS = 4'hC
  - GCMD_NONE = 3'd0
  - an instruction-pack function
- One natural sub-module, instruction_encoder: a combinational packer of the fields into the 21-bit word. It is reused by the read and write sequencers.
- The tri-state driver lives in this block; the enable is (state != IDLE) || start_i.

## Test plan
- Reset, then idle with start_i=0 for 10 cycles -> instruction_o all Z; done_o=0; busy_o=0.
- start_i pulse, address_i=6'h2A, source_i=2'b01 -> instruction_o = 21'h0D4260, 21'h0D4A60, 21'h0D5260, 21'h0D5A60 on four consecutive cycles; done_o high only on the 4th; Z afterwards.
- Change address_i to 6'h00 and source_i to 2'b10 one cycle after start -> beats 1..3 still carry 8'hA9..8'hAB and input_select=01.
- start_i held high continuously, address_i=6'h3F -> bursts repeat every 4 cycles with addresses 8'hFC..8'hFF; no gap cycle; done_o every 4th cycle.
- rst_i asserted during BEAT2 -> next cycle IDLE, instruction_o Z, done_o never pulses; a fresh start then produces a full four-beat burst.
- start_i pulsed during BEAT1 and BEAT2 -> ignored; exactly four beats issued; busy_o pattern 0,1,1,1,0.
